// File: rtl/lc3_mem_arbiter.sv
// LC-3 memory port arbiter: shares one memory port between the CPU control FSM and a DMA requester.
// Round-robin on ties, one access in flight, fixed MEM_LAT-cycle access followed by a one-cycle ready.
module lc3_mem_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_r,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_r,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // state  | meaning
  // IDLE   | waiting for a request; arbitrates on every edge
  // ACCESS | mem_en held, counter runs down to 0
  // DONE   | owner's ready pulses, read data presented
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  owner_t            owner, owner_nxt;
  owner_t            last_grant, last_grant_nxt;
  owner_t            winner;
  logic              lat_we, lat_we_nxt;
  logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_nxt;
  logic [DATA_W-1:0] rdata_q, rdata_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      owner      <= OWN_CPU;
      last_grant <= OWN_DMA;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata_q    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      lat_we     <= lat_we_nxt;
      lat_addr   <= lat_addr_nxt;
      lat_wdata  <= lat_wdata_nxt;
      rdata_q    <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    lat_we_nxt     = lat_we;
    lat_addr_nxt   = lat_addr;
    lat_wdata_nxt  = lat_wdata;
    rdata_nxt      = rdata_q;
    // DMA wins only when alone or when the CPU had the previous grant
    winner = (dma_req && (!cpu_req || last_grant == OWN_CPU)) ? OWN_DMA : OWN_CPU;
    case (state)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          owner_nxt      = winner;
          last_grant_nxt = winner;
          lat_we_nxt     = (winner == OWN_DMA) ? dma_we    : cpu_we;
          lat_addr_nxt   = (winner == OWN_DMA) ? dma_addr  : cpu_addr;
          lat_wdata_nxt  = (winner == OWN_DMA) ? dma_wdata : cpu_wdata;
          cnt_nxt        = CNT_INIT;
          state_nxt      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt == '0) begin
          rdata_nxt = mem_rdata;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem_en    = (state == S_ACCESS);
  assign mem_we    = mem_en & lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_r     = (state == S_DONE) && (owner == OWN_CPU);
  assign dma_r     = (state == S_DONE) && (owner == OWN_DMA);
  assign cpu_rdata = rdata_q;
  assign dma_rdata = rdata_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level round-robin/memory model.
module tb_lc3_mem_arbiter;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_r, dma_r, mem_en, mem_we;
  logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;

  int checks = 0;
  int errors = 0;

  logic [15:0] dev_mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  bit          model_last_dma;

  lc3_mem_arbiter #(.MEM_LAT(LAT), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_r(cpu_r), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_r(dma_r), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // memory device: writes on the edge, read data refreshed mid-cycle
  always @(posedge clk) if (mem_en && mem_we) dev_mem[mem_addr] = mem_wdata;
  always @(negedge clk) mem_rdata = dev_mem[mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call just after an edge with requests already applied; returns just after the edge ending DONE.
  task automatic observe(input bit own_dma, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rdata,
                         input bit chk_rd, input int drop);
    @(negedge clk);
    chk("pre_mem_en", {31'b0, mem_en}, 32'd0);
    @(posedge clk);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("acc_mem_en", {31'b0, mem_en}, 32'd1);
      chk("acc_mem_we", {31'b0, mem_we}, {31'b0, we});
      chk("acc_mem_addr", {16'b0, mem_addr}, {16'b0, addr});
      chk("acc_mem_wdata", {16'b0, mem_wdata}, {16'b0, wdata});
      chk("acc_ready", {30'b0, cpu_r, dma_r}, 32'd0);
      if (k == drop) begin
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("done_mem_en", {31'b0, mem_en}, 32'd0);
    chk("done_cpu_r", {31'b0, cpu_r}, {31'b0, !own_dma});
    chk("done_dma_r", {31'b0, dma_r}, {31'b0, own_dma});
    if (chk_rd) chk("done_rdata", {16'b0, own_dma ? dma_rdata : cpu_rdata}, {16'b0, rdata});
    @(posedge clk);
    #1;
  endtask

  // Reference: round-robin choice and memory contents at transaction level.
  task automatic serve(input int drop);
    bit          c, d, win_dma, we;
    logic [15:0] addr, wdata, rd;
    c = cpu_req;
    d = dma_req;
    win_dma = d && (!c || !model_last_dma);
    model_last_dma = win_dma;
    we    = win_dma ? dma_we    : cpu_we;
    addr  = win_dma ? dma_addr  : cpu_addr;
    wdata = win_dma ? dma_wdata : cpu_wdata;
    rd = ref_mem[addr];
    if (we) ref_mem[addr] = wdata;
    observe(win_dma, we, addr, wdata, rd, !we, drop);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_last_dma = 1'b1;
  endtask

  initial begin
    int pulses;
    int en_seen;
    for (int i = 0; i < 65536; i++) begin
      dev_mem[i] = 16'(i) ^ 16'h5A5A;
      ref_mem[i] = 16'(i) ^ 16'h5A5A;
    end
    dev_mem[16'h3000] = 16'h1234;
    ref_mem[16'h3000] = 16'h1234;

    // reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
      dma_req = 1'($urandom); dma_we = 1'($urandom);
      dma_addr = 16'($urandom); dma_wdata = 16'($urandom);
      @(negedge clk);
      chk("rst_outputs", {26'b0, mem_en, mem_we, cpu_r, dma_r, |mem_addr, |mem_wdata}, 32'd0);
      chk("rst_rdata", {cpu_rdata, dma_rdata}, 32'd0);
      @(posedge clk);
      #1;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    rst = 1'b0;
    model_last_dma = 1'b1;
    en_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en_seen += int'(mem_en);
    end
    chk("idle_no_en", 32'(en_seen), 32'd0);
    @(posedge clk);
    #1;

    // CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000; cpu_wdata = 16'h0;
    serve(0);
    cpu_req = 1'b0;

    // DMA write
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'hFE06; dma_wdata = 16'h00AA;
    serve(0);
    dma_req = 1'b0;
    chk("dma_write_mem", {16'b0, dev_mem[16'hFE06]}, 32'h00AA);

    // tie after reset, both held: CPU, DMA, CPU
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200;
    serve(0);
    serve(0);
    serve(0);
    cpu_req = 1'b0; dma_req = 1'b0;

    // reset in cycle 2 of a CPU write
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort_pre_en", {31'b0, mem_en}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_async", {29'b0, mem_en, mem_we, cpu_r}, 32'd0);
    cpu_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_last_dma = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pulses += int'(cpu_r) + int'(dma_r) + int'(mem_en);
    end
    chk("abort_no_ready", 32'(pulses), 32'd0);
    @(posedge clk);
    #1;
    ref_mem[16'h0300] = dev_mem[16'h0300];
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
    serve(0);
    cpu_req = 1'b0;

    // request dropped in cycle 2
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
    serve(2);
    en_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en_seen += int'(mem_en) + int'(cpu_r);
    end
    chk("drop_stays_idle", 32'(en_seen), 32'd0);
    @(posedge clk);
    #1;

    // random traffic over a small address window
    for (int i = 0; i < 30; i++) begin
      cpu_req = 1'($urandom); dma_req = 1'($urandom);
      if (!cpu_req && !dma_req) cpu_req = 1'b1;
      cpu_we = 1'($urandom); dma_we = 1'($urandom);
      cpu_addr = 16'h4000 + 16'($urandom_range(0, 7));
      dma_addr = 16'h4000 + 16'($urandom_range(0, 7));
      cpu_wdata = 16'($urandom); dma_wdata = 16'($urandom);
      serve(0);
    end
    cpu_req = 1'b0; dma_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
